switch_debounce3: RTL and testbench

Three-channel synchronizer and debouncer that sits directly upstream of the `xy' + yz` sum-of-products stage. It takes raw, asynchronous, bouncing switch inputs and presents clean, clock-synchronous `x`, `y`, `z` levels to the combinational logic. It also raises a one-cycle `changed` strobe whenever any debounced level updates.

---
 rtl/switch_debounce3.sv | 117 +++++++++++
 tb/tb_switch_debounce3.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce3.sv
// Three-channel switch synchronizer and debouncer feeding the x/y/z sum-of-products stage.
// Each channel commits a new level only after STABLE_CYCLES consecutive disagreeing samples.
module switch_debounce3 #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw_in,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       changed
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_out;
  logic [2:0] w_commit;
  logic       r_changed;

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("switch_debounce3: STABLE_CYCLES out of range for CNT_W");
  end

  // Two-flop synchronizer; metastability is confined to r_sync1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_out;
    logic             w_outNext;
    logic             w_commitCh;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
        r_out   <= 1'b0;
      end else begin
        r_state <= w_stateNext;
        r_cnt   <= w_cntNext;
        r_out   <= w_outNext;
      end
    end

    // Any agreeing sample while counting aborts and forces a full restart of the window.
    always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_outNext   = r_out;
      w_commitCh  = 1'b0;
      case (r_state)
        ST_STABLE: begin
          if (r_sync2[i] != r_out) begin
            w_stateNext = ST_COUNTING;
            w_cntNext   = LP_ONE;
          end
        end
        ST_COUNTING: begin
          if (r_sync2[i] == r_out) begin
            w_stateNext = ST_STABLE;
            w_cntNext   = '0;
          end else if (r_cnt == LP_LAST) begin
            w_stateNext = ST_STABLE;
            w_cntNext   = '0;
            w_outNext   = r_sync2[i];
            w_commitCh  = 1'b1;
          end else begin
            w_cntNext   = r_cnt + LP_ONE;
          end
        end
        default: begin
          w_stateNext = ST_STABLE;
          w_cntNext   = '0;
        end
      endcase
    end

    assign w_out[i]    = r_out;
    assign w_commit[i] = w_commitCh;
  end

  // Simultaneous commits merge into one pulse; back-to-back commits keep it high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_commit;
    end
  end

  assign x       = w_out[2];
  assign y       = w_out[1];
  assign z       = w_out[0];
  assign changed = r_changed;

endmodule

// File: tb/tb_switch_debounce3.sv
// Scoreboard bench for switch_debounce3: stimulus queues expected commits, a negedge
// monitor pops one entry per changed pulse and checks level and cycle of arrival.
module tb_switch_debounce3;

  localparam int LP_STABLE = 4;
  localparam int LP_CNT_W  = 3;
  localparam int LP_LAT    = LP_STABLE + 2;

  typedef struct {
    logic [2:0] xyz;
    int         cycle;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw_in;
  logic       x;
  logic       y;
  logic       z;
  logic       changed;

  exp_t       expQ[$];
  logic [2:0] lastXyz;
  int         cycle;
  int         checks;
  int         errors;

  switch_debounce3 #(
    .STABLE_CYCLES(LP_STABLE),
    .CNT_W        (LP_CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .x      (x),
    .y      (y),
    .z      (z),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  // Monitor: pops on every changed pulse, otherwise the levels must hold their last committed value.
  always @(negedge clk) begin
    if (!rst_n) begin
      checks = checks + 1;
      if ({x, y, z} != 3'b000 || changed !== 1'b0) begin
        errors = errors + 1;
        $display("[TB] FAIL resetHold: xyz=%b changed=%b, required xyz=000 changed=0", {x, y, z}, changed);
      end
      lastXyz = 3'b000;
    end else if (changed === 1'b1) begin
      checks = checks + 1;
      if (expQ.size() == 0) begin
        errors = errors + 1;
        $display("[TB] FAIL unexpectedChanged: changed=1 at cycle %0d xyz=%b, required changed=0", cycle, {x, y, z});
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if ({x, y, z} !== e.xyz) begin
          errors = errors + 1;
          $display("[TB] FAIL commitLevel: xyz=%b, required %b", {x, y, z}, e.xyz);
        end
        checks = checks + 1;
        if (cycle != e.cycle) begin
          errors = errors + 1;
          $display("[TB] FAIL commitCycle: pulse at cycle %0d, required cycle %0d", cycle, e.cycle);
        end
        lastXyz = e.xyz;
      end
    end else begin
      checks = checks + 1;
      if ({x, y, z} !== lastXyz) begin
        errors = errors + 1;
        $display("[TB] FAIL holdLevel: xyz=%b at cycle %0d without changed, required %b", {x, y, z}, cycle, lastXyz);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives sw_in at the current negedge and, if a commit is due, queues it LP_LAT edges later.
  task automatic applyStimulus(input logic [2:0] sw, input bit expectCommit, input logic [2:0] expXyz);
    exp_t e;
    sw_in = sw;
    if (expectCommit) begin
      e.xyz   = expXyz;
      e.cycle = cycle + LP_LAT;
      expQ.push_back(e);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] required);
    checks = checks + 1;
    if (actual !== required) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: {xyz,changed}=%b, required %b", name, actual, required);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    cycle   = 0;
    lastXyz = 3'b000;
    rst_n   = 1'b0;
    sw_in   = 3'b111;

    // Reset values, immediately and while held
    #1;
    checkOutput("resetImmediate", {x, y, z, changed}, 4'b0000);
    waitCycles(4);
    checkOutput("resetHeld", {x, y, z, changed}, 4'b0000);
    sw_in = 3'b000;
    #2 rst_n = 1'b1;
    waitCycles(4);

    // Clean edge on x
    applyStimulus(3'b100, 1'b1, 3'b100);
    waitCycles(10);

    // Bounce rejection on y, then a steady 1
    for (int k = 0; k < 5; k++) begin
      applyStimulus(3'b110, 1'b0, 3'b000);
      waitCycles(3);
      applyStimulus(3'b100, 1'b0, 3'b000);
      waitCycles(3);
    end
    checkOutput("bounceRejected", {x, y, z, changed}, 4'b1000);
    applyStimulus(3'b110, 1'b1, 3'b110);
    waitCycles(10);

    // Simultaneous commits: fall to 000, then rise to 011
    applyStimulus(3'b000, 1'b1, 3'b000);
    waitCycles(10);
    applyStimulus(3'b011, 1'b1, 3'b011);
    waitCycles(10);

    // Staggered channels: x then z one edge later
    applyStimulus(3'b000, 1'b1, 3'b000);
    waitCycles(10);
    applyStimulus(3'b100, 1'b1, 3'b100);
    waitCycles(1);
    applyStimulus(3'b101, 1'b1, 3'b101);
    waitCycles(10);
    checkOutput("staggeredFinal", {x, y, z, changed}, 4'b1010);

    // Reset mid-count: y is counting when reset hits, x and z drop at once
    applyStimulus(3'b111, 1'b0, 3'b000);
    waitCycles(3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("resetMidCount", {x, y, z, changed}, 4'b0000);
    waitCycles(3);
    #2 rst_n = 1'b1;
    applyStimulus(3'b111, 1'b1, 3'b111);
    waitCycles(10);
    checkOutput("afterResetCommit", {x, y, z, changed}, 4'b1110);

    checks = checks + 1;
    if (expQ.size() != 0) begin
      errors = errors + 1;
      $display("[TB] FAIL pendingCommits: %0d expected commits never seen, required 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
